inst_fetch_ctrl: RTL

Sequencer for the synchronous instruction memory `inst_mem`. It holds the program counter and drives the memory's `rd_en`/`rd_addr`, accounting for the memory's one-cycle read latency. It presents fetched instructions to decode over a valid/ready handshake and services redirects from branch/jump resolution. It sits between `inst_mem` and the decode stage and supports one instruction per cycle at full throughput.

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_stall_ctr.sv | 20 ++
 rtl/inst_fetch_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package ifetch_pkg;

  typedef enum logic {
    IFETCH_IDLE,
    IFETCH_VALID
  } ifetch_state_t;

  // Fold an address back to 0 once it runs past the end of a mem_size-deep memory.
  function automatic int unsigned ifetch_wrap(input int unsigned x, input int unsigned mem_size);
    return (x >= mem_size) ? 32'd0 : x;
  endfunction

endpackage

// File: rtl/ifetch_stall_ctr.sv
// Saturating stall-cycle counter, only built when IFETCH_STALL_CNT_EN is defined.
`ifdef IFETCH_STALL_CNT_EN
module ifetch_stall_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule
`endif

// File: rtl/inst_fetch_ctrl.sv
// PC sequencer for a 1-cycle-latency instruction memory with valid/ready output and redirect.
// Optional: IFETCH_STALL_CNT_EN adds a saturating stall_cycles counter port.
module inst_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int RESET_PC   = 0,
  localparam int ADDR_W    = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [INST_WIDTH-1:0] mem_instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_instr,
  output logic [ADDR_W-1:0]     out_pc
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  ifetch_state_t     state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] resp_pc, resp_pc_nxt;
  logic [ADDR_W-1:0] tgt;

  // Out-of-range targets only exist for non-power-of-two depths; they restart at 0.
  assign tgt = ADDR_W'(ifetch_wrap(32'(redirect_pc), MEM_SIZE));

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    resp_pc_nxt = resp_pc;
    mem_rd_en   = en && !rst && (redirect_valid || (state == IFETCH_IDLE) || out_ready);
    mem_rd_addr = redirect_valid ? tgt : pc;

    if (mem_rd_en) begin
      resp_pc_nxt = mem_rd_addr;
      pc_nxt      = ADDR_W'(ifetch_wrap(32'(mem_rd_addr) + 32'd1, MEM_SIZE));
      state_nxt   = IFETCH_VALID;
    end else if (redirect_valid) begin
      // Fetch disabled: remember the target and drop whatever the memory holds.
      pc_nxt    = tgt;
      state_nxt = IFETCH_IDLE;
    end else if ((state == IFETCH_VALID) && out_ready) begin
      state_nxt = IFETCH_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IFETCH_IDLE;
      pc      <= ADDR_W'(RESET_PC);
      resp_pc <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      resp_pc <= resp_pc_nxt;
    end
  end

  // The memory output register is the holding buffer; a stall simply stops re-reading it.
  assign out_valid = (state == IFETCH_VALID) && !redirect_valid;
  assign out_pc    = resp_pc;
  assign out_instr = out_valid ? mem_instruction : '0;

`ifdef IFETCH_STALL_CNT_EN
  ifetch_stall_ctr #(.W(32)) u_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .count (stall_cycles)
  );
`endif

endmodule
